// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters.
// Requests are arbitrated round-robin. The winner's operands are registered
// onto the ALU inputs, the result is captured after ALU_LAT cycles, and it is
// returned to the winner over a valid/ready response channel.
// Only one operation is in flight at a time.
// Optional grant counters are enabled by the ALU_ARB_STATS_EN macro.
//
// Handshake semantics (both directions): a transfer happens on a rising edge
// where valid && ready. On the request side, ready is combinational from
// valid and is high only in IDLE, and only for the arbitration winner. On the
// response side, valid is registered and holds stable data until the ready
// edge.
module alu_share_arbiter #(
  parameter int W       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic         req0_slt,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [W-1:0] resp0_data,
  output logic         resp0_zero,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic         req1_slt,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [W-1:0] resp1_data,
  output logic         resp1_zero,
  output logic [W-1:0] alu_srcA,
  output logic [W-1:0] alu_srcB,
  output logic [2:0]   alu_ctrl,
  output logic         alu_slt,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  output logic [1:0]   dbg_state
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic         stats_clr,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic [3:0]   lat_cnt_q, lat_cnt_d;
  logic [W-1:0] src_a_q, src_a_d;
  logic [W-1:0] src_b_q, src_b_d;
  logic [2:0]   ctrl_q, ctrl_d;
  logic         slt_q, slt_d;
  logic         rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic         rzero0_q, rzero0_d, rzero1_q, rzero1_d;
  logic         win0, win1;

  // State, holding and response registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      lat_cnt_q    <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      ctrl_q       <= '0;
      slt_q        <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rzero0_q     <= 1'b0;
      rzero1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      ctrl_q       <= ctrl_d;
      slt_q        <= slt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rzero0_q     <= rzero0_d;
      rzero1_q     <= rzero1_d;
    end
  end

  // Arbitration, next-state logic and request readys.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    ctrl_d       = ctrl_q;
    slt_d        = slt_q;
    rvalid0_d    = rvalid0_q;
    rvalid1_d    = rvalid1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rzero0_d     = rzero0_q;
    rzero1_d     = rzero1_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // A lone requester wins; on a tie the one not granted last time wins.
    win0 = req0_valid && (!req1_valid || last_grant_q);
    win1 = req1_valid && (!req0_valid || !last_grant_q);
    case (state_q)
      S_IDLE: begin
        req0_ready = win0;
        req1_ready = win1;
        if (win0 || win1) begin
          owner_d      = win1;
          last_grant_d = win1;
          lat_cnt_d    = LAT_INIT;
          src_a_d      = win1 ? req1_a   : req0_a;
          src_b_d      = win1 ? req1_b   : req0_b;
          ctrl_d       = win1 ? req1_op  : req0_op;
          slt_d        = win1 ? req1_slt : req0_slt;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (lat_cnt_q == 4'd0) state_d = S_CAPT;
        else lat_cnt_d = lat_cnt_q - 4'd1;
      end
      S_CAPT: begin
        if (owner_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = alu_result;
          rzero1_d  = alu_zero;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = alu_result;
          rzero0_d  = alu_zero;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) begin
          rvalid0_d = 1'b0;
          rvalid1_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_srcA    = src_a_q;
  assign alu_srcB    = src_b_q;
  assign alu_ctrl    = ctrl_q;
  assign alu_slt     = slt_q;
  assign resp0_valid = rvalid0_q;
  assign resp0_data  = rdata0_q;
  assign resp0_zero  = rzero0_q;
  assign resp1_valid = rvalid1_q;
  assign resp1_data  = rdata1_q;
  assign resp1_zero  = rzero1_q;
  assign dbg_state   = state_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating per-requester grant counters; clear wins over an accept.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (req0_valid && req0_ready && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
      if (req1_valid && req1_ready && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter. The main instance runs with ALU_LAT=1 and is
// checked every cycle against a transaction-level model. A second instance
// with ALU_LAT=4 covers reset during EXEC. Grant counters are covered when
// ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;
  localparam int W   = 32;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // ---------------- main instance signals ----------------
  logic         req0_valid = 0, req1_valid = 0, resp0_ready = 1, resp1_ready = 1;
  logic [2:0]   req0_op = 0, req1_op = 0;
  logic         req0_slt = 0, req1_slt = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic         req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, resp1_zero;
  logic [W-1:0] resp0_data, resp1_data, alu_srcA, alu_srcB, alu_result;
  logic [2:0]   alu_ctrl;
  logic         alu_slt, alu_zero;
  logic [1:0]   dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic         stats_clr = 0;
  logic [15:0]  grant_cnt0, grant_cnt1, q_cnt0, q_cnt1;
`endif

  // Execution unit: integer ops plus signed SLT path.
  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic slt,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (slt) return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  assign alu_result = alu_f(alu_ctrl, alu_slt, alu_srcA, alu_srcB);
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter #(.W(W), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_slt(req0_slt),
    .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_slt(req1_slt),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_zero(resp1_zero),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl), .alu_slt(alu_slt),
    .alu_result(alu_result), .alu_zero(alu_zero), .dbg_state(dbg_state)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // ---------------- second instance, ALU_LAT=4 ----------------
  logic         q_rst_n = 1'b0, q0_valid = 0;
  logic [2:0]   q0_op = 0;
  logic [W-1:0] q0_a = 0, q0_b = 0;
  logic         q0_ready, q1_ready, qr0_valid, qr1_valid, qr0_zero, qr1_zero;
  logic [W-1:0] qr0_data, qr1_data, q_srca, q_srcb, q_res;
  logic [2:0]   q_ctrl;
  logic         q_slt, q_zero;
  logic [1:0]   q_dbg;

  assign q_res  = alu_f(q_ctrl, q_slt, q_srca, q_srcb);
  assign q_zero = (q_res == '0);

  alu_share_arbiter #(.W(W), .ALU_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(q_rst_n),
    .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_op(q0_op), .req0_slt(1'b0),
    .req0_a(q0_a), .req0_b(q0_b),
    .resp0_valid(qr0_valid), .resp0_ready(1'b1), .resp0_data(qr0_data), .resp0_zero(qr0_zero),
    .req1_valid(1'b0), .req1_ready(q1_ready), .req1_op(3'd0), .req1_slt(1'b0),
    .req1_a('0), .req1_b('0),
    .resp1_valid(qr1_valid), .resp1_ready(1'b1), .resp1_data(qr1_data), .resp1_zero(qr1_zero),
    .alu_srcA(q_srca), .alu_srcB(q_srcb), .alu_ctrl(q_ctrl), .alu_slt(q_slt),
    .alu_result(q_res), .alu_zero(q_zero), .dbg_state(q_dbg)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr(1'b0), .grant_cnt0(q_cnt0), .grant_cnt1(q_cnt1)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model and scoreboard ----------------
  // The model tracks one transaction by its age in cycles since accept.
  logic [W-1:0] exp_q[$];
  int           grant_q[$];
  bit           m_busy, m_owner, m_last;
  int           m_age;
  logic [W-1:0] m_a, m_b;
  logic [2:0]   m_op;
  logic         m_slt;

  always @(negedge clk) begin
    bit w0, w1, v0e, v1e;
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
      m_a = '0; m_b = '0; m_op = '0; m_slt = 0;
      exp_q.delete();
      grant_q.delete();
    end else begin
      w0  = req0_valid && (!req1_valid || m_last);
      w1  = req1_valid && (!req0_valid || !m_last);
      v0e = m_busy && !m_owner && (m_age >= LAT + 1);
      v1e = m_busy &&  m_owner && (m_age >= LAT + 1);
      chk("req0_ready", req0_ready, !m_busy && w0);
      chk("req1_ready", req1_ready, !m_busy && w1);
      chk("alu_srcA", alu_srcA, m_a);
      chk("alu_srcB", alu_srcB, m_b);
      chk("alu_ctrl", alu_ctrl, m_op);
      chk("alu_slt", alu_slt, m_slt);
      chk("resp0_valid", resp0_valid, v0e);
      chk("resp1_valid", resp1_valid, v1e);
      if (v0e && exp_q.size() > 0) begin
        chk("resp0_data", resp0_data, exp_q[0]);
        chk("resp0_zero", resp0_zero, exp_q[0] == '0);
      end
      if (v1e && exp_q.size() > 0) begin
        chk("resp1_data", resp1_data, exp_q[0]);
        chk("resp1_zero", resp1_zero, exp_q[0] == '0);
      end
      // Advance to what the next edge does.
      if (m_busy) begin
        if ((v0e && resp0_ready) || (v1e && resp1_ready)) begin
          m_busy = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          m_age++;
        end
      end else if (w0 || w1) begin
        m_busy  = 1;
        m_owner = w1;
        m_last  = w1;
        m_age   = 0;
        m_a     = w1 ? req1_a   : req0_a;
        m_b     = w1 ? req1_b   : req0_b;
        m_op    = w1 ? req1_op  : req0_op;
        m_slt   = w1 ? req1_slt : req0_slt;
        exp_q.push_back(alu_f(m_op, m_slt, m_a, m_b));
        grant_q.push_back(int'(w1));
      end
    end
  end

  // Watches the ALU_LAT=4 instance for any response.
  bit saw_resp4 = 0;
  always @(negedge clk) if (q_rst_n && (qr0_valid || qr1_valid)) saw_resp4 = 1;

  // ---------------- driver tasks ----------------
  task automatic drive(input int r, input logic [2:0] op, input logic slt,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (r == 0) begin req0_valid = 1; req0_op = op; req0_slt = slt; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1; req1_op = op; req1_slt = slt; req1_a = a; req1_b = b; end
  endtask

  // Returns just after the accept edge with that requester's valid dropped.
  task automatic wait_accept(input int r);
    bit hit = 0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      hit = (r == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    chk("accept_seen", hit, 1'b1);
    @(posedge clk); #1;
    if (r == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // Counts edges from the accept edge until resp valid is seen.
  task automatic wait_resp(input int r, output int n);
    bit hit = 0;
    n = 0;
    while (!hit && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      hit = (r == 0) ? resp0_valid : resp1_valid;
    end
    chk("resp_seen", hit, 1'b1);
  endtask

  task automatic txn(input int r, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    drive(r, op, 1'b0, a, b);
    wait_accept(r);
    wait_resp(r, n);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
    @(negedge clk);
    chk("rst_srcA", alu_srcA, 0);
    chk("rst_srcB", alu_srcB, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_slt", alu_slt, 0);
    chk("rst_v0", resp0_valid, 0);
    chk("rst_v1", resp1_valid, 0);
    chk("rst_d0", resp0_data, 0);
    chk("rst_d1", resp1_data, 0);
    chk("rst_z0", resp0_zero, 0);
    chk("rst_z1", resp1_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0] tbl_a[6] = '{32'd10, 32'd20, 32'hFFFF_FFFE, 32'h0F0F, 32'd9, 32'd1};
  logic [W-1:0] tbl_b[6] = '{32'd3, 32'd20, 32'd2, 32'hF0F0, 32'd9, 32'd4};
  logic [2:0]   tbl_op[6] = '{3'd1, 3'd1, 3'd0, 3'd3, 3'd4, 3'd6};
  logic         tbl_slt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int           exp_g[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    int n, k;
    bit hit;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; q_rst_n = 1;
    do_reset();

    // Single request: 5 + 7.
    @(posedge clk); #1;
    drive(0, 3'b000, 1'b0, 32'd5, 32'd7);
    wait_accept(0);
    @(negedge clk);
    chk("t1_srcA", alu_srcA, 32'd5);
    chk("t1_srcB", alu_srcB, 32'd7);
    wait_resp(0, n);
    chk("t1_latency", n, 2);
    chk("t1_data", resp0_data, 32'd12);
    chk("t1_zero", resp0_zero, 1'b0);
    @(posedge clk); #1;

    // Simultaneous requests straight after reset.
    do_reset();
    @(posedge clk); #1;
    drive(0, 3'b001, 1'b0, 32'd1, 32'd1);
    drive(1, 3'b001, 1'b0, 32'd3, 32'd3);
    wait_accept(0);
    wait_resp(0, n);
    chk("t2_data0", resp0_data, 32'd0);
    chk("t2_zero0", resp0_zero, 1'b1);
    @(posedge clk); #1;
    wait_accept(1);
    wait_resp(1, n);
    chk("t2_data1", resp1_data, 32'd0);
    chk("t2_zero1", resp1_zero, 1'b1);
    chk("t2_grants", grant_q.size(), 2);
    chk("t2_first", grant_q[0], 0);
    chk("t2_second", grant_q[1], 1);
    @(posedge clk); #1;

    // Round-robin with both requesters continuously valid.
    grant_q.delete();
    drive(0, tbl_op[0], tbl_slt[0], tbl_a[0], tbl_b[0]);
    drive(1, tbl_op[1], tbl_slt[1], tbl_a[1], tbl_b[1]);
    k = 0;
    for (int c = 0; c < 200 && k < 6; c++) begin
      @(negedge clk);
      hit = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      if (hit) begin
        @(posedge clk); #1;
        k++;
        if (k < 5) begin
          if (req0_ready) drive(0, tbl_op[k+1], tbl_slt[k+1], tbl_a[k+1], tbl_b[k+1]);
          else            drive(1, tbl_op[k+1], tbl_slt[k+1], tbl_a[k+1], tbl_b[k+1]);
        end
      end
    end
    req0_valid = 0; req1_valid = 0;
    chk("t3_grant_count", k, 6);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), grant_q[i], exp_g[i]);

    // Response backpressure on requester 1, requester 0 pending.
    resp1_ready = 0;
    drive(1, 3'b010, 1'b0, 32'hF0, 32'h3C);
    wait_accept(1);
    drive(0, 3'b000, 1'b0, 32'd1, 32'd2);
    wait_resp(1, n);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_hold_valid", resp1_valid, 1'b1);
      chk("t4_hold_data", resp1_data, 32'h30);
      chk("t4_req0_wait", req0_ready, 1'b0);
    end
    @(posedge clk); #1 resp1_ready = 1;
    @(negedge clk);
    chk("t4_last_valid", resp1_valid, 1'b1);
    chk("t4_req0_still", req0_ready, 1'b0);
    @(negedge clk);
    chk("t4_valid_clr", resp1_valid, 1'b0);
    chk("t4_req0_go", req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 0;
    wait_resp(0, n);
    chk("t4_lat0", n, 2);
    chk("t4_data0", resp0_data, 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of EXEC on the ALU_LAT=4 instance.
    q0_valid = 1; q0_op = 3'b000; q0_a = 32'd9; q0_b = 32'd9;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin @(negedge clk); hit = q0_ready; end
    chk("t5_accept", hit, 1'b1);
    @(posedge clk); #1 q0_valid = 0;
    @(negedge clk);
    chk("t5_srcA_set", q_srca, 32'd9);
    repeat (2) @(posedge clk);
    #1 q_rst_n = 0;
    #1;
    chk("t5_srcA", q_srca, 0);
    chk("t5_srcB", q_srcb, 0);
    chk("t5_ctrl", q_ctrl, 0);
    chk("t5_v0", qr0_valid, 0);
    chk("t5_d0", qr0_data, 0);
    chk("t5_rdy", q0_ready, 0);
    @(posedge clk); #1 q_rst_n = 1;
    saw_resp4 = 0;
    repeat (10) @(negedge clk);
    chk("t5_no_resp", saw_resp4, 1'b0);
    @(posedge clk); #1;
    q0_valid = 1; q0_a = 32'd2; q0_b = 32'd3;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin @(negedge clk); hit = q0_ready; end
    chk("t5_accept2", hit, 1'b1);
    @(posedge clk); #1 q0_valid = 0;
    hit = 0; n = 0;
    while (!hit && n < 40) begin @(posedge clk); n++; @(negedge clk); hit = qr0_valid; end
    chk("t5_latency", n, 5);
    chk("t5_data", qr0_data, 32'd5);
    chk("t5_zero", qr0_zero, 1'b0);
    @(posedge clk); #1;

`ifdef ALU_ARB_STATS_EN
    // Grant counters.
    stats_clr = 1;
    @(posedge clk); #1 stats_clr = 0;
    chk("st_clr0", grant_cnt0, 0);
    chk("st_clr1", grant_cnt1, 0);
    txn(0, 3'd0, 32'd1, 32'd1);
    txn(0, 3'd2, 32'd6, 32'd3);
    txn(1, 3'd3, 32'd4, 32'd8);
    txn(0, 3'd4, 32'd5, 32'd5);
    chk("st_cnt0", grant_cnt0, 16'd3);
    chk("st_cnt1", grant_cnt1, 16'd1);
    stats_clr = 1;
    @(posedge clk); #1 stats_clr = 0;
    chk("st_reclr0", grant_cnt0, 0);
    chk("st_reclr1", grant_cnt1, 0);
`else
    txn(0, 3'd5, 32'd0, 32'd0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
